// File: rtl/dshot_frame_tx.sv
// -----------------------------------------------------------------------------
// dshot_frame_tx
//
// DShot frame serializer placed directly downstream of the baudrate tick
// generator. A frame request latches an 11-bit throttle value and a telemetry
// bit, appends a 4-bit CRC, and shifts the resulting 16-bit word out MSB first.
// Each bit is shaped into a single ESC pulse from the generator's phase outputs.
// The frame is followed by GAP_BITS bit periods of idle level, after which the
// block returns to ready.
//
// Handshake: start/ready follow valid/ready semantics. A request is accepted
// on a rising clk_in edge where start=1 and ready=1. ready is high only in IDLE.
// A start seen while busy is dropped and is not queued.
//
// Parameters
//   GAP_BITS   idle bit periods appended after bit 0 (1..15)
//   INVERTED   1 = bidirectional DShot: idle-high, line and CRC inverted
//
// Ports
//   clk_in      in   system clock, shared with the baudrate generator
//   reset       in   synchronous, active-high
//   start       in   frame request
//   throttle    in   [10:0] throttle/command value, sampled at accept
//   telem       in   telemetry request bit, sampled at accept
//   ready       out  1 while IDLE
//   baud_en     out  enable for the baudrate generator
//   bit_tick    in   generator clk_out: 1-cycle pulse on the last cycle of a bit
//   half_in     in   generator half_clk_out phase
//   quarter_in  in   generator quarter_clk_out phase
//   dshot_out   out  registered line output to the ESC
//   frame_done  out  1-cycle pulse on the cycle the gap ends
//   state_dbg   out  [1:0] current FSM state (0=IDLE, 1=SEND, 2=GAP)
// -----------------------------------------------------------------------------
module dshot_frame_tx #(
    parameter int GAP_BITS = 4,
    parameter bit INVERTED = 1'b0
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] throttle,
    input  logic        telem,
    output logic        ready,
    output logic        baud_en,
    input  logic        bit_tick,
    input  logic        half_in,
    input  logic        quarter_in,
    output logic        dshot_out,
    output logic        frame_done,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP_BITS - 1);
    localparam logic       IDLE_LVL = INVERTED;

    state_t      state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [3:0]  gapcnt_q, gapcnt_d;
    logic        dshot_q, dshot_d;

    // Frame word built combinationally from the live inputs so it can be
    // loaded into the shift register on the accept edge.
    logic [11:0] payload;
    logic [3:0]  crc_raw;
    logic [3:0]  crc;
    logic [15:0] frame_word;

    assign payload    = {throttle, telem};
    assign crc_raw    = payload[3:0] ^ payload[7:4] ^ payload[11:8];
    assign crc        = INVERTED ? ~crc_raw : crc_raw;
    assign frame_word = {payload, crc};

    // Pulse shaping for the current bit. A '1' stays high except when both
    // phases are set (last quarter); a '0' is high only while neither phase
    // is set (early part of the bit).
    logic cur_bit;
    logic pulse_high;

    assign cur_bit    = shift_q[15];
    assign pulse_high = cur_bit ? !(half_in & quarter_in)
                                : (!half_in & !quarter_in);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bitcnt_d   = bitcnt_q;
        gapcnt_d   = gapcnt_q;
        dshot_d    = IDLE_LVL;
        ready      = 1'b0;
        baud_en    = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_d  = SEND;
                    shift_d  = frame_word;
                    bitcnt_d = 4'd15;
                    gapcnt_d = 4'd0;
                end
            end

            SEND: begin
                baud_en = 1'b1;
                dshot_d = pulse_high ^ IDLE_LVL;
                if (bit_tick) begin
                    shift_d = {shift_q[14:0], 1'b0};
                    if (bitcnt_q == 4'd0) begin
                        state_d  = GAP;
                        gapcnt_d = GAP_LAST;
                    end else begin
                        bitcnt_d = bitcnt_q - 4'd1;
                    end
                end
            end

            GAP: begin
                baud_en = 1'b1;
                if (bit_tick) begin
                    if (gapcnt_q == 4'd0) begin
                        // baud_en drops with the state change on the next edge
                        state_d    = IDLE;
                        frame_done = 1'b1;
                    end else begin
                        gapcnt_d = gapcnt_q - 4'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q  <= IDLE;
            shift_q  <= 16'd0;
            bitcnt_q <= 4'd0;
            gapcnt_q <= 4'd0;
            dshot_q  <= IDLE_LVL;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            gapcnt_q <= gapcnt_d;
            dshot_q  <= dshot_d;
        end
    end

    assign dshot_out = dshot_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_dshot_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_dshot_frame_tx
//
// Two serializers (normal and inverted) each driven by a small model of the
// baudrate generator at 20 clk_in per bit. Stimulus pushes the hand-computed
// 16-bit frame into a per-instance expected queue; a monitor per instance
// detects each frame start, pops the expected word, and checks every bit's
// 20-cycle waveform, the idle gap, frame_done timing and the return to ready.
// -----------------------------------------------------------------------------
module tb_dshot_frame_tx;

    logic        clk_in = 1'b0;
    logic        reset;
    logic [1:0]  start;
    logic [10:0] throttle [2];
    logic [1:0]  telem;
    logic [1:0]  ready;
    logic [1:0]  baud_en;
    logic [1:0]  bit_tick;
    logic [1:0]  half_in;
    logic [1:0]  quarter_in;
    logic [1:0]  dshot_out;
    logic [1:0]  frame_done;
    logic [1:0]  state_dbg [2];

    logic [4:0]  cnt [2];
    int          cyc = 0;

    int          errors = 0;
    int          checks = 0;

    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];

    // ---------------- clock / reset ----------------
    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs ----------------
    dshot_frame_tx #(.GAP_BITS(4), .INVERTED(1'b0)) u0 (
        .clk_in(clk_in), .reset(reset), .start(start[0]),
        .throttle(throttle[0]), .telem(telem[0]), .ready(ready[0]),
        .baud_en(baud_en[0]), .bit_tick(bit_tick[0]), .half_in(half_in[0]),
        .quarter_in(quarter_in[0]), .dshot_out(dshot_out[0]),
        .frame_done(frame_done[0]), .state_dbg(state_dbg[0])
    );

    dshot_frame_tx #(.GAP_BITS(4), .INVERTED(1'b1)) u1 (
        .clk_in(clk_in), .reset(reset), .start(start[1]),
        .throttle(throttle[1]), .telem(telem[1]), .ready(ready[1]),
        .baud_en(baud_en[1]), .bit_tick(bit_tick[1]), .half_in(half_in[1]),
        .quarter_in(quarter_in[1]), .dshot_out(dshot_out[1]),
        .frame_done(frame_done[1]), .state_dbg(state_dbg[1])
    );

    // Baudrate generator model: counter held at 0 while disabled,
    // 20 cycles per bit. half = cnt>=10; quarter high on 6..9 and 16..19,
    // giving a '1' pulse of 16 cycles and a '0' pulse of 6 cycles.
    always @(posedge clk_in) begin
        for (int i = 0; i < 2; i++) begin
            if (reset || !baud_en[i]) cnt[i] <= 5'd0;
            else if (cnt[i] == 5'd19) cnt[i] <= 5'd0;
            else cnt[i] <= cnt[i] + 5'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            bit_tick[i]   = (cnt[i] == 5'd19);
            half_in[i]    = (cnt[i] >= 5'd10);
            quarter_in[i] = ((cnt[i] >= 5'd6) && (cnt[i] < 5'd10)) || (cnt[i] >= 5'd16);
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic monitor(input int idx);
        logic [15:0] fr;
        logic        inv;
        logic [19:0] act;
        logic [19:0] expv;
        int          gap_bad;
        int          done_bad;
        bit          ab;
        int          k;
        int          c;
        inv = (idx == 1);
        forever begin
            @(negedge clk_in);
            if (baud_en[idx] && !reset) begin
                fr = 16'd0;
                if (idx == 0 && exp_q0.size() > 0) fr = exp_q0.pop_front();
                else if (idx == 1 && exp_q1.size() > 0) fr = exp_q1.pop_front();
                else check($sformatf("u%0d unexpected frame", idx), 1, 0);
                act = '0; ab = 0; gap_bad = 0; done_bad = 0;
                for (int j = 1; j < 400; j++) begin
                    @(negedge clk_in);
                    if (reset) begin
                        ab = 1;
                        break;
                    end
                    if (j <= 320) begin
                        k = (j - 1) / 20;
                        c = (j - 1) % 20;
                        act[19 - c] = dshot_out[idx];
                        if (c == 19) begin
                            expv = fr[15 - k] ? 20'hFFFF0 : 20'hFC000;
                            if (inv) expv = ~expv;
                            check($sformatf("u%0d frame %04h bit%0d", idx, fr, 15 - k), 32'(act), 32'(expv));
                        end
                    end else if (dshot_out[idx] !== inv) begin
                        gap_bad++;
                    end
                    if (frame_done[idx] !== (j == 399)) done_bad++;
                end
                if (!ab) begin
                    check($sformatf("u%0d gap idle level", idx), gap_bad, 0);
                    check($sformatf("u%0d frame_done timing", idx), done_bad, 0);
                    @(negedge clk_in);
                    check($sformatf("u%0d ready/baud_en/done after frame", idx),
                          {29'd0, ready[idx], baud_en[idx], frame_done[idx]}, 32'b100);
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    // ---------------- driver tasks ----------------
    task automatic wait_ready(input int idx);
        bit seen;
        seen = 0;
        for (int n = 0; n < 1000 && !seen; n++) begin
            @(negedge clk_in);
            if (ready[idx]) seen = 1;
        end
        check($sformatf("u%0d ready seen", idx), 32'(seen), 1);
    endtask

    task automatic wait_done(input int idx);
        bit seen;
        seen = 0;
        for (int n = 0; n < 1000 && !seen; n++) begin
            @(negedge clk_in);
            if (frame_done[idx]) seen = 1;
        end
        check($sformatf("u%0d frame_done seen", idx), 32'(seen), 1);
    endtask

    task automatic push_exp(input int idx, input logic [15:0] fr);
        if (idx == 0) exp_q0.push_back(fr);
        else exp_q1.push_back(fr);
    endtask

    task automatic send(input int idx, input logic [10:0] thr, input logic tel, input logic [15:0] fr);
        wait_ready(idx);
        throttle[idx] = thr;
        telem[idx]    = tel;
        start[idx]    = 1'b1;
        push_exp(idx, fr);
        @(posedge clk_in);
        #1 start[idx] = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int t0;
        int t1;
        bit seen;
        bit busy;
        reset       = 1'b1;
        start       = 2'b00;
        throttle[0] = 11'd0;
        throttle[1] = 11'd0;
        telem       = 2'b00;
        repeat (3) @(posedge clk_in);
        #1 reset = 1'b0;
        @(negedge clk_in);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d reset ready", i), 32'(ready[i]), 1);
            check($sformatf("u%0d reset baud_en", i), 32'(baud_en[i]), 0);
            check($sformatf("u%0d reset dshot_out", i), 32'(dshot_out[i]), (i == 1) ? 1 : 0);
            check($sformatf("u%0d reset frame_done", i), 32'(frame_done[i]), 0);
            check($sformatf("u%0d reset state", i), 32'(state_dbg[i]), 0);
        end

        // throttle 1046, telem 0 -> 0x82C6
        send(0, 11'd1046, 1'b0, 16'h82C6);
        wait_done(0);
        // throttle 0, telem 1 -> 0x0011
        send(0, 11'd0, 1'b1, 16'h0011);
        wait_done(0);
        // inverted instance: CRC nibble becomes 0x9
        send(1, 11'd1046, 1'b0, 16'h82C9);
        wait_done(1);

        // start held through SEND/GAP and on the frame_done cycle: one frame only
        wait_ready(0);
        throttle[0] = 11'h2AA;
        telem[0]    = 1'b0;
        start[0]    = 1'b1;
        push_exp(0, 16'h5544);
        wait_done(0);
        start[0] = 1'b0;
        busy = 0;
        repeat (30) begin
            @(negedge clk_in);
            if (baud_en[0]) busy = 1;
        end
        check("u0 no restart after held start", 32'(busy), 0);

        // reset during bit 7 aborts the frame
        wait_ready(0);
        throttle[0] = 11'h3FF;
        telem[0]    = 1'b0;
        start[0]    = 1'b1;
        push_exp(0, 16'h7FE6);
        @(posedge clk_in);
        #1 start[0] = 1'b0;
        repeat (150) @(posedge clk_in);
        #1 reset = 1'b1;
        @(posedge clk_in);
        #1 reset = 1'b0;
        @(negedge clk_in);
        check("u0 abort ready", 32'(ready[0]), 1);
        check("u0 abort baud_en", 32'(baud_en[0]), 0);
        check("u0 abort dshot_out", 32'(dshot_out[0]), 0);
        send(0, 11'h3FF, 1'b0, 16'h7FE6);
        wait_done(0);

        // back-to-back with start held high
        wait_ready(0);
        throttle[0] = 11'd100;
        telem[0]    = 1'b1;
        start[0]    = 1'b1;
        push_exp(0, 16'h0C95);
        @(posedge clk_in);
        #1;
        throttle[0] = 11'd1046;
        telem[0]    = 1'b1;
        push_exp(0, 16'h82D7);
        wait_done(0);
        t0 = cyc;
        seen = 0;
        t1 = t0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk_in);
            if (baud_en[0]) begin
                seen = 1;
                t1 = cyc;
            end
        end
        start[0] = 1'b0;
        check("u0 back-to-back restart seen", 32'(seen), 1);
        check("u0 frame_done to next baud_en cycles", t1 - t0, 2);
        wait_done(0);

        repeat (5) @(negedge clk_in);
        check("u0 expected queue drained", exp_q0.size(), 0);
        check("u1 expected queue drained", exp_q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
